// File: rtl/svo_bounce_src_if.sv
// AXI4-Stream pixel bus used by the SVO video pipeline.
//   tvalid : pixel valid (master -> slave)
//   tready : downstream accept (slave -> master)
//   tdata  : 24-bit RGB pixel, [23:16] R, [15:8] G, [7:0] B
//   tuser  : start of frame, set on pixel (0,0)
interface svo_bounce_src_if #(
  parameter int DW = 24
);
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tuser;

  modport master (output tvalid, output tdata, output tuser, input tready);
  modport slave  (input tvalid, input tdata, input tuser, output tready);
endinterface

// File: rtl/svo_bounce_src.sv
// svo_bounce_src: synthetic video source. Emits an endless stream of
// active-area frames with a solid box moving diagonally and bouncing off
// the frame edges.
//
// Ports:
//   clk      : pixel clock
//   resetn   : asynchronous active-low reset
//   pause    : freezes box motion; sampled only on the last-pixel accept
//   out_axis : AXI4-Stream master (tvalid/tready/tdata/tuser)
//
// Optional feature: define SVO_BOUNCE_GRADIENT_EN to replace the black
// background with {x[7:0], y[7:0], fcnt}.
module svo_bounce_src #(
  parameter int          H_PIXELS  = 640,
  parameter int          V_PIXELS  = 480,
  parameter int          BOX_SIZE  = 64,
  parameter int          STEP      = 2,
  parameter logic [23:0] BOX_COLOR = 24'hFFFFFF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pause,
  svo_bounce_src_if.master  out_axis
);

  localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int YW = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;

  // All box arithmetic runs one bit wider than the coordinate so that
  // position + step / position + size never wraps.
  localparam logic [XW:0]   BX_MAX = (XW+1)'(H_PIXELS - BOX_SIZE);
  localparam logic [YW:0]   BY_MAX = (YW+1)'(V_PIXELS - BOX_SIZE);
  localparam logic [XW:0]   STEP_X = (XW+1)'(STEP);
  localparam logic [YW:0]   STEP_Y = (YW+1)'(STEP);
  localparam logic [XW:0]   BOX_X  = (XW+1)'(BOX_SIZE);
  localparam logic [YW:0]   BOX_Y  = (YW+1)'(BOX_SIZE);
  localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_PIXELS - 1);

  // x/y index the pixel currently held in the output register
  logic [XW-1:0] x, x_n, bx, bx_n;
  logic [YW-1:0] y, y_n, by, by_n;
  logic          dx, dx_n, dy, dy_n;
  logic          tvalid;
  logic [23:0]   tdata, pix;
  logic          tuser;
  logic          accept, load, eol, eof, in_box;
`ifdef SVO_BOUNCE_GRADIENT_EN
  logic [7:0]    fcnt, fcnt_n;
`endif

  assign accept = tvalid & out_axis.tready;
  // Reload when the held beat leaves, or fill an empty register after reset
  assign load   = accept | ~tvalid;
  assign eol    = (x == X_LAST);
  assign eof    = eol && (y == Y_LAST);

  always_comb begin
    x_n  = x;
    y_n  = y;
    bx_n = bx;
    by_n = by;
    dx_n = dx;
    dy_n = dy;
`ifdef SVO_BOUNCE_GRADIENT_EN
    fcnt_n = fcnt;
`endif
    if (accept) begin
      if (eol) begin
        x_n = '0;
        y_n = eof ? '0 : y + 1'b1;
      end else begin
        x_n = x + 1'b1;
      end

      if (eof) begin
`ifdef SVO_BOUNCE_GRADIENT_EN
        fcnt_n = fcnt + 8'd1;
`endif
        if (!pause) begin
          // X axis: clamp to the edge and reverse instead of overshooting
          if (dx) begin
            if ({1'b0, bx} + STEP_X >= BX_MAX) begin
              bx_n = BX_MAX[XW-1:0];
              dx_n = 1'b0;
            end else begin
              bx_n = XW'({1'b0, bx} + STEP_X);
            end
          end else begin
            if ({1'b0, bx} <= STEP_X) begin
              bx_n = '0;
              dx_n = 1'b1;
            end else begin
              bx_n = XW'({1'b0, bx} - STEP_X);
            end
          end
          // Y axis: same rule
          if (dy) begin
            if ({1'b0, by} + STEP_Y >= BY_MAX) begin
              by_n = BY_MAX[YW-1:0];
              dy_n = 1'b0;
            end else begin
              by_n = YW'({1'b0, by} + STEP_Y);
            end
          end else begin
            if ({1'b0, by} <= STEP_Y) begin
              by_n = '0;
              dy_n = 1'b1;
            end else begin
              by_n = YW'({1'b0, by} - STEP_Y);
            end
          end
        end
      end
    end
  end

  // Pixel for the next coordinates, so a new frame's (0,0) already sees
  // the updated box.
  always_comb begin
    in_box = ({1'b0, x_n} >= {1'b0, bx_n}) && ({1'b0, x_n} < {1'b0, bx_n} + BOX_X) &&
             ({1'b0, y_n} >= {1'b0, by_n}) && ({1'b0, y_n} < {1'b0, by_n} + BOX_Y);
`ifdef SVO_BOUNCE_GRADIENT_EN
    pix = in_box ? BOX_COLOR : {8'(x_n), 8'(y_n), fcnt_n};
`else
    pix = in_box ? BOX_COLOR : 24'h000000;
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x      <= '0;
      y      <= '0;
      bx     <= '0;
      by     <= '0;
      dx     <= 1'b1;
      dy     <= 1'b1;
      tvalid <= 1'b0;
      tdata  <= '0;
      tuser  <= 1'b0;
`ifdef SVO_BOUNCE_GRADIENT_EN
      fcnt   <= '0;
`endif
    end else begin
      x  <= x_n;
      y  <= y_n;
      bx <= bx_n;
      by <= by_n;
      dx <= dx_n;
      dy <= dy_n;
`ifdef SVO_BOUNCE_GRADIENT_EN
      fcnt <= fcnt_n;
`endif
      if (load) begin
        tvalid <= 1'b1;
        tdata  <= pix;
        tuser  <= (x_n == '0) && (y_n == '0);
      end
    end
  end

  assign out_axis.tvalid = tvalid;
  assign out_axis.tdata  = tdata;
  assign out_axis.tuser  = tuser;

endmodule

// File: tb/tb_svo_bounce_src.sv
// Self-checking bench for svo_bounce_src: 8x4 frame, 2x2 box, step 1.
module tb_svo_bounce_src;
  localparam int H = 8, V = 4, BOX = 2, STEP = 1, FB = H * V;

  logic clk = 1'b0, resetn = 1'b0, pause = 1'b0;
  always #5 clk = ~clk;

  svo_bounce_src_if axis ();

  svo_bounce_src #(
    .H_PIXELS(H), .V_PIXELS(V), .BOX_SIZE(BOX), .STEP(STEP), .BOX_COLOR(24'hFFFFFF)
  ) dut (
    .clk(clk), .resetn(resetn), .pause(pause), .out_axis(axis)
  );

  int checks = 0, errors = 0;

  // Hand-derived box origins: bx bounces 0..6, by bounces 0..2
  int bxt [12] = '{0, 1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1};
  int byt [4]  = '{0, 1, 2, 1};

  int f, m, n, fw;  // frame index, motion index, beat in frame, first box beat

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (frame %0d beat %0d)", tag, obs, exp, f, n);
    end
  endtask

  function automatic logic [23:0] exp_pix(int x, int y, int bx, int by, int fr);
    if (x >= bx && x < bx + BOX && y >= by && y < by + BOX) return 24'hFFFFFF;
`ifdef SVO_BOUNCE_GRADIENT_EN
    return {8'(x), 8'(y), 8'(fr)};
`else
    return 24'h000000;
`endif
  endfunction

  task automatic model_reset();
    f = 0; m = 0; n = 0; fw = -1;
  endtask

  // Stream `beats` accepted beats; rnd gives ~50% tready; pause is raised
  // while the last beat of frame pause_f is presented.
  task automatic run(input int beats, input bit rnd, input int pause_f);
    int done = 0, cyc = 0;
    bit stalled = 0, rdy, pz;
    logic [23:0] pd = '0;
    logic pu = 1'b0;
    while (done < beats) begin
      @(negedge clk);
      cyc++;
      if (cyc > beats * 8 + 100) begin
        chk("timeout", done, beats);
        return;
      end
      chk("tvalid", axis.tvalid, 1'b1);
      if (stalled) begin
        chk("hold_data", axis.tdata, pd);
        chk("hold_user", axis.tuser, pu);
      end
      pz = (f == pause_f) && (n == FB - 1);
      pause = pz;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      axis.tready = rdy;
      if (rdy) begin
        chk("tdata", axis.tdata, exp_pix(n % H, n / H, bxt[m % 12], byt[m % 4], f));
        chk("tuser", axis.tuser, (n == 0));
        if (f == 0 && n == 2) chk("pix_2_0", axis.tdata, 24'h000000);
        if (fw < 0 && axis.tdata == 24'hFFFFFF) fw = n;
        stalled = 0;
        n++;
        done++;
        if (n == FB) begin
          chk("origin", fw, byt[m % 4] * H + bxt[m % 12]);
          n = 0; fw = -1; f++;
          if (!pz) m++;
        end
      end else begin
        stalled = 1;
        pd = axis.tdata;
        pu = axis.tuser;
      end
    end
  endtask

  initial begin
    axis.tready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_tvalid", axis.tvalid, 1'b0);
    chk("rst_tdata", axis.tdata, 24'h0);
    chk("rst_tuser", axis.tuser, 1'b0);

    // First beat after release is pixel (0,0) with the box at the origin
    resetn = 1'b1;
    @(negedge clk);
    chk("first_valid", axis.tvalid, 1'b1);
    chk("first_user", axis.tuser, 1'b1);
    chk("first_data", axis.tdata, 24'hFFFFFF);

    run(12 * FB, 1'b0, -1);   // frames 0..11, full rate
    run(2 * FB, 1'b1, -1);    // frames 12..13, random backpressure
    run(3 * FB, 1'b0, 14);    // pause at end of frame 14

    // Reset mid-frame while stalled on pixel (5,2) of frame 3
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    run(3 * FB + 21, 1'b0, -1);
    @(posedge clk);
    #1 axis.tready = 1'b0;
    @(negedge clk);
    chk("stall_52_data", axis.tdata, exp_pix(5, 2, 3, 1, 3));
    chk("stall_52_user", axis.tuser, 1'b0);
    #2 resetn = 1'b0;
    #1;
    chk("async_tvalid", axis.tvalid, 1'b0);
    chk("async_tdata", axis.tdata, 24'h0);
    chk("async_tuser", axis.tuser, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    @(negedge clk);
    chk("rerun_user", axis.tuser, 1'b1);
    chk("rerun_data", axis.tdata, 24'hFFFFFF);
    run(2 * FB, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
